// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among execution-unit
// result ports, feeding a single registered broadcast stage that drives
// the reservation stations and commit logic.
module cdb_arbiter #(
    parameter  int NUM_UNITS   = 4,
    parameter  int RS_ID_WIDTH = 5,
    parameter  int FLAG_WIDTH  = 8,
    localparam int UNIT_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [NUM_UNITS-1:0]              unit_valid,
    output logic [NUM_UNITS-1:0]              unit_ready,
    input  logic [NUM_UNITS*RS_ID_WIDTH-1:0]  unit_rs_id,
    input  logic [NUM_UNITS*5-1:0]            unit_reg_addr,
    input  logic [NUM_UNITS*32-1:0]           unit_result,
    input  logic [NUM_UNITS*FLAG_WIDTH-1:0]   unit_flags,
    output logic                              cdb_valid,
    input  logic                              cdb_ready,
    output logic [RS_ID_WIDTH-1:0]            cdb_rs_id,
    output logic [4:0]                        cdb_reg_addr,
    output logic [31:0]                       cdb_value,
    output logic [FLAG_WIDTH-1:0]             cdb_flags,
    output logic [UNIT_W-1:0]                 cdb_unit
);

    // ------------------------------------------------------------------
    // Per-unit payload views (unit i lives at slice i of each bus)
    // ------------------------------------------------------------------
    logic [RS_ID_WIDTH-1:0] rs_id_arr   [NUM_UNITS];
    logic [4:0]             reg_arr     [NUM_UNITS];
    logic [31:0]            result_arr  [NUM_UNITS];
    logic [FLAG_WIDTH-1:0]  flags_arr   [NUM_UNITS];
    logic [NUM_UNITS-1:0]   req;

    // ------------------------------------------------------------------
    // Broadcast stage state
    // ------------------------------------------------------------------
    logic                   cdb_valid_q;
    logic [RS_ID_WIDTH-1:0] cdb_rs_id_q;
    logic [4:0]             cdb_reg_addr_q;
    logic [31:0]            cdb_value_q;
    logic [FLAG_WIDTH-1:0]  cdb_flags_q;
    logic [UNIT_W-1:0]      cdb_unit_q;
    logic [UNIT_W-1:0]      rr_ptr_q;
    logic [UNIT_W-1:0]      rr_ptr_d;

    // ------------------------------------------------------------------
    // Arbitration signals
    // ------------------------------------------------------------------
    logic                   load_en;
    logic                   grant_any;
    logic [UNIT_W-1:0]      grant_idx;
    logic [UNIT_W:0]        cand;
    logic                   xfer;

    // The stage can take a new result when it is empty or its current
    // broadcast is being consumed; a flush suppresses any new grant, and
    // no grant is ever issued while reset is held.
    assign load_en = rst && !flush && (!cdb_valid_q || cdb_ready);

    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unpack
            assign rs_id_arr[gi]  = unit_rs_id[gi*RS_ID_WIDTH +: RS_ID_WIDTH];
            assign reg_arr[gi]    = unit_reg_addr[gi*5 +: 5];
            assign result_arr[gi] = unit_result[gi*32 +: 32];
            assign flags_arr[gi]  = unit_flags[gi*FLAG_WIDTH +: FLAG_WIDTH];
            assign req[gi]        = unit_valid[gi] && load_en;
        end
    endgenerate

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = {1'b0, rr_ptr_q} + (UNIT_W+1)'(k);
            if (cand >= (UNIT_W+1)'(NUM_UNITS)) begin
                cand = cand - (UNIT_W+1)'(NUM_UNITS);
            end
            if (!grant_any && req[cand[UNIT_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[UNIT_W-1:0];
            end
        end
    end

    // One-hot grant back to the winning unit (all zero when no grant).
    always_comb begin
        unit_ready = '0;
        if (grant_any) begin
            unit_ready[grant_idx] = 1'b1;
        end
    end

    // A grant always completes a handshake because the winner is valid.
    assign xfer = grant_any;

    // Pointer moves to the unit just after the winner so it gets lowest
    // priority next time.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            if (grant_idx == UNIT_W'(NUM_UNITS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + UNIT_W'(1);
            end
        end
    end

    // Broadcast stage: load on transfer, drain on accept, drop on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_q    <= 1'b0;
            cdb_rs_id_q    <= '0;
            cdb_reg_addr_q <= '0;
            cdb_value_q    <= '0;
            cdb_flags_q    <= '0;
            cdb_unit_q     <= '0;
            rr_ptr_q       <= '0;
        end else begin
            if (flush) begin
                cdb_valid_q <= 1'b0;
            end else if (xfer) begin
                cdb_valid_q    <= 1'b1;
                cdb_rs_id_q    <= rs_id_arr[grant_idx];
                cdb_reg_addr_q <= reg_arr[grant_idx];
                cdb_value_q    <= result_arr[grant_idx];
                cdb_flags_q    <= flags_arr[grant_idx];
                cdb_unit_q     <= grant_idx;
                rr_ptr_q       <= rr_ptr_d;
            end else if (cdb_valid_q && cdb_ready) begin
                cdb_valid_q <= 1'b0;
            end
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_rs_id    = cdb_rs_id_q;
    assign cdb_reg_addr = cdb_reg_addr_q;
    assign cdb_value    = cdb_value_q;
    assign cdb_flags    = cdb_flags_q;
    assign cdb_unit     = cdb_unit_q;

endmodule
